// File: rtl/osiris_pkg.sv
// Shared definitions for the osiris bus fabric: arbiter state encoding,
// arbitration mode constants and a one-hot decode helper.
package osiris_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWNED = 2'd1,
      ST_ERR   = 2'd2
   } arb_state_t;

   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   // Index of the set bit in a one-hot vector of up to eight masters.
   function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
      onehot_to_idx = '0;
      for (int i = 0; i < 8; i++) begin
         if (oh[i]) onehot_to_idx = 3'(i);
      end
   endfunction

endpackage

// File: rtl/osiris_prio_pick.sv
// Combinational one-hot picker: the first requester found when scanning
// upwards from i_base (wrapping modulo N) wins.
module osiris_prio_pick #(
   parameter int N  = 2,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_base,
   output logic [N-1:0]  o_win
);

   logic [IW:0] w_sum;

   // Scan from the farthest offset down so the nearest requester is written last.
   always_comb begin
      o_win = '0;
      w_sum = '0;
      for (int k = N - 1; k >= 0; k--) begin
         w_sum = {1'b0, i_base} + (IW + 1)'(k);
         if (w_sum >= (IW + 1)'(N)) w_sum = w_sum - (IW + 1)'(N);
         if (i_req[w_sum[IW-1:0]]) begin
            o_win = '0;
            o_win[w_sum[IW-1:0]] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/osiris_wb_arbiter.sv
// N-master to 1-slave Wishbone classic arbiter with bus locking,
// fixed-priority or round-robin selection and a stalled-slave watchdog.
module osiris_wb_arbiter
   import osiris_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int NUM_MASTERS    = 2,
   parameter int RR_MODE        = 0,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_MASTERS-1:0]            m_cyc_i,
   input  logic [NUM_MASTERS-1:0]            m_stb_i,
   input  logic [NUM_MASTERS-1:0]            m_we_i,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
   output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_o,
   output logic [NUM_MASTERS-1:0]            m_ack_o,
   output logic [NUM_MASTERS-1:0]            m_err_o,
   output logic                              s_cyc_o,
   output logic                              s_stb_o,
   output logic                              s_we_o,
   output logic [ADDR_WIDTH-1:0]             s_adr_o,
   output logic [DATA_WIDTH-1:0]             s_dat_o,
   input  logic [DATA_WIDTH-1:0]             s_dat_i,
   input  logic                              s_ack_i,
   output logic [NUM_MASTERS-1:0]            grant_o,
   output logic                              busy_o,
   output logic [1:0]                        dbg_state_o
);

   localparam int N    = NUM_MASTERS;
   localparam int IW   = $clog2(N);
   localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [WD_W-1:0] WD_MAX   = WD_W'(TIMEOUT_CYCLES);
   localparam logic [IW-1:0]   LAST_RST = IW'(N - 1);

   arb_state_t        r_state;
   logic [N-1:0]      r_grant;
   logic [N-1:0]      r_err;
   logic [IW-1:0]     r_last;
   logic [WD_W-1:0]   r_wdog;

   logic [N-1:0]      w_req;
   logic [N-1:0]      w_win;
   logic [7:0]        w_win8;
   logic [IW-1:0]     w_base;
   logic              w_owned;
   logic              w_timeout;
   logic              w_cyc_g;
   logic              w_stb_g;
   logic              w_we_g;
   logic [ADDR_WIDTH-1:0] w_adr_g;
   logic [DATA_WIDTH-1:0] w_dat_g;

   assign w_req  = m_cyc_i & m_stb_i;
   assign w_win8 = 8'(w_win);
   assign w_base = (RR_MODE == ARB_RR) ?
                   ((r_last == LAST_RST) ? '0 : r_last + IW'(1)) : '0;

   osiris_prio_pick #(
      .N  (N),
      .IW (IW)
   ) u_pick (
      .i_req  (w_req),
      .i_base (w_base),
      .o_win  (w_win)
   );

   // Select the granted master's request lines; r_grant is one-hot or zero.
   always_comb begin
      w_cyc_g = 1'b0;
      w_stb_g = 1'b0;
      w_we_g  = 1'b0;
      w_adr_g = '0;
      w_dat_g = '0;
      for (int i = 0; i < N; i++) begin
         if (r_grant[i]) begin
            w_cyc_g = m_cyc_i[i];
            w_stb_g = m_stb_i[i];
            w_we_g  = m_we_i[i];
            w_adr_g = m_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            w_dat_g = m_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Handshake: a beat completes in any cycle where cyc, stb and the slave's
   // ack are all high; the master may hold cyc across beats to keep the bus.
   assign w_owned = (r_state == ST_OWNED);
   assign s_cyc_o = w_owned & w_cyc_g;
   assign s_stb_o = w_owned & w_stb_g;
   assign s_we_o  = w_owned & w_we_g;
   assign s_adr_o = w_owned ? w_adr_g : '0;
   assign s_dat_o = w_owned ? w_dat_g : '0;
   assign m_ack_o = w_owned ? (r_grant & {N{s_ack_i}}) : '0;
   assign m_err_o = r_err;
   assign m_dat_o = {N{s_dat_i}};

   assign grant_o     = r_grant;
   assign busy_o      = (r_state != ST_IDLE);
   assign dbg_state_o = r_state;

   assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_wdog == WD_MAX) &&
                      w_stb_g && !s_ack_i;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_grant <= '0;
         r_err   <= '0;
         r_last  <= LAST_RST;
         r_wdog  <= '0;
      end else begin
         r_err <= '0;
         case (r_state)
            ST_IDLE: begin
               r_wdog <= '0;
               if (|w_req) begin
                  r_grant <= w_win;
                  r_last  <= IW'(onehot_to_idx(w_win8));
                  r_state <= ST_OWNED;
               end
            end
            ST_OWNED: begin
               if (!w_cyc_g) begin
                  r_state <= ST_IDLE;
                  r_grant <= '0;
                  r_wdog  <= '0;
               end else if (w_timeout) begin
                  r_state <= ST_ERR;
                  r_err   <= r_grant;
                  r_wdog  <= '0;
               end else if (s_ack_i || !w_stb_g) begin
                  r_wdog <= '0;
               end else if (r_wdog != WD_MAX) begin
                  r_wdog <= r_wdog + WD_W'(1);
               end
            end
            ST_ERR: begin
               // Slave stays released until the master gives up its cycle.
               if (!w_cyc_g) begin
                  r_state <= ST_IDLE;
                  r_grant <= '0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_grant <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_osiris_wb_arbiter.sv
// Bench for osiris_wb_arbiter: a 2-master fixed-priority instance and a
// 4-master round-robin instance driven with directed cycle-by-cycle vectors.
module tb_osiris_wb_arbiter;
   import osiris_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int RW = 70;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // instance A: 2 masters, fixed priority, 8-cycle watchdog
   logic [1:0]      a_cyc, a_stb, a_we, a_ack, a_err, a_grant, a_state;
   logic [2*AW-1:0] a_adr;
   logic [2*DW-1:0] a_dat, a_mdat;
   logic            a_scyc, a_sstb, a_swe, a_sack, a_busy;
   logic [AW-1:0]   a_sadr;
   logic [DW-1:0]   a_sdat_o, a_sdat_i;

   // instance B: 4 masters, round-robin, watchdog disabled
   logic [3:0]      b_cyc, b_stb, b_we, b_ack, b_err, b_grant;
   logic [1:0]      b_state;
   logic [4*AW-1:0] b_adr;
   logic [4*DW-1:0] b_dat, b_mdat;
   logic            b_scyc, b_sstb, b_swe, b_sack, b_busy;
   logic [AW-1:0]   b_sadr;
   logic [DW-1:0]   b_sdat_o, b_sdat_i;

   osiris_wb_arbiter #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_MASTERS(2),
      .RR_MODE(ARB_FIXED), .TIMEOUT_CYCLES(8)
   ) dut_a (
      .clk(clk), .rst(rst),
      .m_cyc_i(a_cyc), .m_stb_i(a_stb), .m_we_i(a_we),
      .m_adr_i(a_adr), .m_dat_i(a_dat), .m_dat_o(a_mdat),
      .m_ack_o(a_ack), .m_err_o(a_err),
      .s_cyc_o(a_scyc), .s_stb_o(a_sstb), .s_we_o(a_swe),
      .s_adr_o(a_sadr), .s_dat_o(a_sdat_o), .s_dat_i(a_sdat_i), .s_ack_i(a_sack),
      .grant_o(a_grant), .busy_o(a_busy), .dbg_state_o(a_state)
   );

   osiris_wb_arbiter #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_MASTERS(4),
      .RR_MODE(ARB_RR), .TIMEOUT_CYCLES(0)
   ) dut_b (
      .clk(clk), .rst(rst),
      .m_cyc_i(b_cyc), .m_stb_i(b_stb), .m_we_i(b_we),
      .m_adr_i(b_adr), .m_dat_i(b_dat), .m_dat_o(b_mdat),
      .m_ack_o(b_ack), .m_err_o(b_err),
      .s_cyc_o(b_scyc), .s_stb_o(b_sstb), .s_we_o(b_swe),
      .s_adr_o(b_sadr), .s_dat_o(b_sdat_o), .s_dat_i(b_sdat_i), .s_ack_i(b_sack),
      .grant_o(b_grant), .busy_o(b_busy), .dbg_state_o(b_state)
   );

   int n_chk  = 0;
   int n_pass = 0;
   logic [RW-1:0] exp_q[$];   // {grant, ack, err, m_dat_o} of instance A
   logic [3:0]    gnt_q[$];   // grant sequence of instance B
   logic [DW-1:0] slave_mem;
   logic [3:0]    oh;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic a_set(input logic m, input logic cyc, input logic stb, input logic we,
                        input logic [AW-1:0] adr, input logic [DW-1:0] dat);
      a_cyc[m] = cyc;
      a_stb[m] = stb;
      a_we[m]  = we;
      a_adr[m*AW +: AW] = adr;
      a_dat[m*DW +: DW] = dat;
   endtask

   // Scoreboard for instance A: every ack/err event is matched in order.
   initial begin : mon_a
      logic [RW-1:0] got;
      logic [RW-1:0] want;
      forever begin
         @(negedge clk);
         if (rst && ((a_ack | a_err) != 2'b00)) begin
            got = {a_grant, a_ack, a_err, a_mdat};
            n_chk++;
            if (exp_q.size() == 0) begin
               $display("FAIL sb_a: unexpected event %0h", got);
            end else begin
               want = exp_q.pop_front();
               if (got === want) n_pass++;
               else $display("FAIL sb_a: got %0h expected %0h", got, want);
            end
         end
      end
   end

   // Scoreboard for instance B: each new nonzero grant is matched in order.
   initial begin : mon_b
      logic [3:0] prev;
      logic [3:0] want;
      prev = '0;
      forever begin
         @(negedge clk);
         if (b_grant !== prev && b_grant != 4'b0000) begin
            n_chk++;
            if (gnt_q.size() == 0) begin
               $display("FAIL sb_b: unexpected grant %0h", b_grant);
            end else begin
               want = gnt_q.pop_front();
               if (b_grant === want) n_pass++;
               else $display("FAIL sb_b: got grant %0h expected %0h", b_grant, want);
            end
         end
         prev = b_grant;
      end
   end

   initial begin : guard
      #100000;
      $display("FAIL global_timeout: bench did not finish, required finish before 100000");
      $fatal(1, "timeout");
   end

   initial begin : drv
      a_cyc = '0; a_stb = '0; a_we = '0; a_adr = '0; a_dat = '0;
      a_sack = 1'b0; a_sdat_i = '0;
      b_cyc = '0; b_stb = '0; b_we = '0; b_dat = '0;
      b_adr = {32'h300, 32'h200, 32'h100, 32'h0};
      b_sack = 1'b0; b_sdat_i = '0;
      slave_mem = '0; oh = '0;

      // reset values
      repeat (2) @(posedge clk);
      smp();
      chk("rst_grant_a", 32'(a_grant), 0);
      chk("rst_busy_a", 32'(a_busy), 0);
      chk("rst_sctl_a", 32'({a_scyc, a_sstb, a_swe}), 0);
      chk("rst_sadr_a", a_sadr, 0);
      chk("rst_ackerr_a", 32'({a_ack, a_err}), 0);
      chk("rst_grant_b", 32'(b_grant), 0);
      step(); rst = 1'b1;

      // single master write of 0xDEADBEEF at 0x10, ack two cycles after strobe
      step(); a_set(0, 1, 1, 1, 32'h10, 32'hDEADBEEF);
      smp(); chk("t1_nogrant", 32'(a_grant), 0); chk("t1_nostb", 32'(a_sstb), 0);
      step(); smp();
      chk("t1_grant", 32'(a_grant), 1);
      chk("t1_sctl", 32'({a_scyc, a_sstb, a_swe}), 7);
      chk("t1_adr", a_sadr, 32'h10);
      chk("t1_wdat", a_sdat_o, 32'hDEADBEEF);
      chk("t1_state", 32'(a_state), 1);
      step(); smp(); chk("t1_noack", 32'(a_ack), 0);
      step(); a_sack = 1'b1;
      exp_q.push_back({2'b01, 2'b01, 2'b00, 64'h0});
      smp(); chk("t1_ack", 32'(a_ack), 1); slave_mem = a_sdat_o;
      step(); a_sack = 1'b0; a_set(0, 0, 0, 0, 0, 0);
      smp(); chk("t1_rel_busy", 32'(a_busy), 1); chk("t1_rel_scyc", 32'(a_scyc), 0);
      step(); smp(); chk("t1_idle", 32'({a_busy, a_grant}), 0);
      step(); a_set(0, 1, 1, 0, 32'h10, 0);
      step(); a_sack = 1'b1; a_sdat_i = slave_mem;
      exp_q.push_back({2'b01, 2'b01, 2'b00, {2{32'hDEADBEEF}}});
      smp(); chk("t1_rd_we", 32'(a_swe), 0);
      step(); a_sack = 1'b0; a_sdat_i = '0; a_set(0, 0, 0, 0, 0, 0);
      step();

      // fixed priority: simultaneous requests, m0 first, m1 two cycles after release
      step(); a_set(0, 1, 1, 0, 32'h30, 0); a_set(1, 1, 1, 1, 32'h20, 32'hCAFE0001);
      step(); a_sack = 1'b1; a_sdat_i = 32'h11111111;
      exp_q.push_back({2'b01, 2'b01, 2'b00, {2{32'h11111111}}});
      smp(); chk("t2_grant_m0", 32'(a_grant), 1); chk("t2_adr_m0", a_sadr, 32'h30);
      step(); a_sack = 1'b0; a_sdat_i = '0; a_set(0, 0, 0, 0, 0, 0);
      smp(); chk("t2_hold", 32'(a_grant), 1);
      step(); smp(); chk("t2_gap", 32'({a_busy, a_grant}), 0);
      step(); a_sack = 1'b1;
      exp_q.push_back({2'b10, 2'b10, 2'b00, 64'h0});
      smp();
      chk("t2_grant_m1", 32'(a_grant), 2);
      chk("t2_adr_m1", a_sadr, 32'h20);
      chk("t2_wdat_m1", a_sdat_o, 32'hCAFE0001);
      step(); a_sack = 1'b0; a_set(1, 0, 0, 0, 0, 0);
      step();

      // lock: m1 4-beat burst while m0 waits
      step(); a_set(1, 1, 1, 1, 32'h40, 32'hB0);
      for (int b = 0; b < 4; b++) begin
         step();
         if (b == 0) a_set(0, 1, 1, 0, 32'h50, 0);
         a_set(1, 1, 1, 1, 32'h40 + 32'(4 * b), 32'hB0 + 32'(b));
         a_sack = 1'b1; a_sdat_i = 32'hA0 + 32'(b);
         exp_q.push_back({2'b10, 2'b10, 2'b00, {2{32'hA0 + 32'(b)}}});
         smp();
         chk("t3_lock_grant", 32'(a_grant), 2);
         chk("t3_beat_adr", a_sadr, 32'h40 + 32'(4 * b));
      end
      step(); a_sack = 1'b0; a_sdat_i = '0; a_set(1, 0, 0, 0, 0, 0);
      smp(); chk("t3_hold_after", 32'(a_grant), 2);
      step(); smp(); chk("t3_gap", 32'(a_grant), 0);
      step(); a_sack = 1'b1;
      exp_q.push_back({2'b01, 2'b01, 2'b00, 64'h0});
      smp(); chk("t3_m0_after", 32'(a_grant), 1); chk("t3_m0_adr", a_sadr, 32'h50);
      step(); a_sack = 1'b0; a_set(0, 0, 0, 0, 0, 0);
      step();

      // watchdog: slave never acks, error nine cycles after the first strobe
      step(); a_set(0, 1, 1, 1, 32'h60, 32'h12345678);
      for (int c = 1; c <= 9; c++) begin
         step(); smp(); chk("t4_no_err", 32'({a_err, a_scyc}), 1);
      end
      step(); exp_q.push_back({2'b01, 2'b00, 2'b01, 64'h0});
      smp();
      chk("t4_err", 32'(a_err), 1);
      chk("t4_release", 32'({a_scyc, a_sstb}), 0);
      chk("t4_state", 32'(a_state), 2);
      step(); a_sack = 1'b1;
      smp(); chk("t4_err_once", 32'(a_err), 0); chk("t4_late_ack", 32'(a_ack), 0);
      step(); a_sack = 1'b0; a_set(0, 0, 0, 0, 0, 0);
      smp(); chk("t4_err_hold", 32'(a_busy), 1);
      step(); smp(); chk("t4_idle", 32'(a_busy), 0);

      // round-robin: all four request, single-beat cycles, grants 0,1,2,3,0
      step(); b_cyc = 4'hF; b_stb = 4'hF;
      for (int g = 0; g < 5; g++) begin
         oh = 4'(1 << (g % 4));
         step(); b_sack = 1'b1; b_sdat_i = 32'h5A5A0000 + 32'(g);
         gnt_q.push_back(oh);
         smp();
         chk("t5_ack", 32'(b_ack), 32'(oh));
         chk("t5_adr", b_sadr, 32'(g % 4) * 32'h100);
         chk("t5_we", 32'(b_swe), 0);
         chk("t5_bcast", b_mdat[3*DW +: DW], 32'h5A5A0000 + 32'(g));
         step(); b_sack = 1'b0; b_sdat_i = '0; b_cyc = b_cyc & ~oh; b_stb = b_stb & ~oh;
         step(); b_cyc = b_cyc | oh; b_stb = b_stb | oh;
      end

      // asynchronous reset mid-transfer, then master 0 wins the first arbitration
      step(); b_sack = 1'b1;
      gnt_q.push_back(4'b0010);
      smp(); chk("t6_pre", 32'(b_grant), 2);
      @(posedge clk); #3; rst = 1'b0; #1;
      chk("t6_rst_out", 32'({b_grant, b_busy, b_scyc, b_sstb, b_ack, b_err}), 0);
      chk("t6_rst_bus", b_sadr | b_sdat_o, 0);
      chk("t6_rst_state", 32'(b_state), 0);
      chk("t6_rst_a", 32'({a_grant, a_busy, a_err}), 0);
      b_sack = 1'b0;
      step(); rst = 1'b1;
      step(); gnt_q.push_back(4'b0001);
      smp(); chk("t6_rr_first", 32'(b_grant), 1);
      step(); b_cyc = '0; b_stb = '0;
      repeat (3) step();

      chk("sb_a_drained", 32'(exp_q.size()), 0);
      chk("sb_b_drained", 32'(gnt_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
